// File: rtl/register_file_nr_1w_bist.sv
// Flop register file: N sync read ports, one byte-enabled write port,
// external test-port mux and an internal March C- self-test engine.
module register_file_nr_1w_bist #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_RPORTS = 2,
   parameter int NUM_BYTE   = DATA_WIDTH/8,
   parameter int DEPTH      = 2**ADDR_WIDTH
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_RPORTS-1:0]            ReadEnable,
   input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] ReadAddr,
   output logic [NUM_RPORTS*DATA_WIDTH-1:0] ReadData,
   input  logic                             WriteEnable,
   input  logic [ADDR_WIDTH-1:0]            WriteAddr,
   input  logic [DATA_WIDTH-1:0]            WriteData,
   input  logic [NUM_BYTE-1:0]              WriteBE,
   output logic [DEPTH*DATA_WIDTH-1:0]      MemContent,
   input  logic                             BIST,
   input  logic                             CSN_T,
   input  logic                             WEN_T,
   input  logic [ADDR_WIDTH-1:0]            A_T,
   input  logic [DATA_WIDTH-1:0]            D_T,
   input  logic [NUM_BYTE-1:0]              BE_T,
   output logic [DATA_WIDTH-1:0]            Q_T,
   input  logic                             bist_start,
   output logic                             bist_busy,
   output logic                             bist_done,
   output logic                             bist_fail,
   output logic [ADDR_WIDTH-1:0]            bist_fail_addr
);

   typedef enum logic [3:0] {
      IDLE, M0, M1, M2, M3, M4, M5, DRAIN, DONE
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] AMAX = '1;
   localparam logic [DATA_WIDTH-1:0] ONES = '1;

   logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;

   state_t                state, nxt;
   logic [ADDR_WIDTH-1:0] addr, nxt_addr;
   logic [ADDR_WIDTH-1:0] pend_addr;
   logic                  ph, nxt_ph;
   logic                  pend, nxt_pend;
   logic                  e_re, e_we, cmp, up, last;
   logic [DATA_WIDTH-1:0] e_wd, exp_val;
   logic [ADDR_WIDTH-1:0] cmp_addr;
   logic                  start_acc, mismatch;

   logic                  r0_en, w_en;
   logic [ADDR_WIDTH-1:0] r0_addr, w_addr;
   logic [DATA_WIDTH-1:0] w_data;
   logic [NUM_BYTE-1:0]   w_be;

   assign MemContent = mem;
   assign Q_T        = ReadData[DATA_WIDTH-1:0];
   assign bist_busy  = (state != IDLE) && (state != DONE);
   assign start_acc  = bist_start && !bist_busy;
   assign mismatch   = cmp && (ReadData[DATA_WIDTH-1:0] != exp_val);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         addr      <= '0;
         ph        <= 1'b0;
         pend      <= 1'b0;
         pend_addr <= '0;
      end else begin
         state     <= nxt;
         addr      <= nxt_addr;
         ph        <= nxt_ph;
         pend      <= nxt_pend;
         pend_addr <= addr;
      end
   end

   always_comb begin
      nxt      = state;
      nxt_addr = addr;
      nxt_ph   = ph;
      nxt_pend = 1'b0;
      e_re     = 1'b0;
      e_we     = 1'b0;
      e_wd     = '0;
      cmp      = 1'b0;
      exp_val  = '0;
      cmp_addr = addr;
      up       = (state == M1) || (state == M2);
      last     = up ? (addr == AMAX) : (addr == '0);
      unique case (state)
         IDLE, DONE: begin
            if (bist_start) begin
               nxt      = M0;
               nxt_addr = '0;
               nxt_ph   = 1'b0;
            end
         end
         M0: begin
            e_we     = 1'b1;
            nxt_addr = addr + 1'b1;
            if (addr == AMAX) nxt = M1;
         end
         M1, M2, M3, M4: begin
            // RD cycle loads port 0; WR cycle checks it and overwrites
            if (!ph) begin
               e_re   = 1'b1;
               nxt_ph = 1'b1;
            end else begin
               cmp     = 1'b1;
               exp_val = (state == M2 || state == M4) ? ONES : '0;
               e_we    = 1'b1;
               e_wd    = (state == M1 || state == M3) ? ONES : '0;
               nxt_ph  = 1'b0;
               nxt_addr = up ? addr + 1'b1 : addr - 1'b1;
               if (last) begin
                  unique case (state)
                     M1: begin nxt = M2; nxt_addr = '0;   end
                     M2: begin nxt = M3; nxt_addr = AMAX; end
                     M3: begin nxt = M4; nxt_addr = AMAX; end
                     default: begin nxt = M5; nxt_addr = '0; end
                  endcase
               end
            end
         end
         M5: begin
            e_re     = 1'b1;
            nxt_pend = 1'b1;
            cmp      = pend;
            cmp_addr = pend_addr;
            nxt_addr = addr + 1'b1;
            if (addr == AMAX) nxt = DRAIN;
         end
         DRAIN: begin
            cmp      = pend;
            cmp_addr = pend_addr;
            nxt      = DONE;
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bist_done      <= 1'b0;
         bist_fail      <= 1'b0;
         bist_fail_addr <= '0;
      end else if (start_acc) begin
         bist_done      <= 1'b0;
         bist_fail      <= 1'b0;
         bist_fail_addr <= '0;
      end else begin
         if (state == DRAIN) bist_done <= 1'b1;
         if (mismatch) begin
            bist_fail <= 1'b1;
            if (!bist_fail) bist_fail_addr <= cmp_addr;
         end
      end
   end

   always_comb begin
      if (bist_busy) begin
         r0_en   = e_re;
         r0_addr = addr;
         w_en    = e_we;
         w_addr  = addr;
         w_data  = e_wd;
         w_be    = '1;
      end else if (BIST) begin
         r0_en   = !CSN_T && WEN_T;
         r0_addr = A_T;
         w_en    = !CSN_T && !WEN_T;
         w_addr  = A_T;
         w_data  = D_T;
         w_be    = BE_T;
      end else begin
         r0_en   = ReadEnable[0];
         r0_addr = ReadAddr[ADDR_WIDTH-1:0];
         w_en    = WriteEnable;
         w_addr  = WriteAddr;
         w_data  = WriteData;
         w_be    = WriteBE;
      end
   end

   always_ff @(posedge clk) begin
      if (w_en) begin
         for (int b = 0; b < NUM_BYTE; b++) begin
            if (w_be[b]) mem[w_addr][b*8 +: 8] <= w_data[b*8 +: 8];
         end
      end
   end

   // Reads see pre-edge contents, so a same-cycle write returns the old word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ReadData <= '0;
      end else begin
         if (r0_en) ReadData[DATA_WIDTH-1:0] <= mem[r0_addr];
         for (int p = 1; p < NUM_RPORTS; p++) begin
            if (bist_busy || BIST)
               ReadData[p*DATA_WIDTH +: DATA_WIDTH] <= '0;
            else if (ReadEnable[p])
               ReadData[p*DATA_WIDTH +: DATA_WIDTH] <=
                  mem[ReadAddr[p*ADDR_WIDTH +: ADDR_WIDTH]];
         end
      end
   end

endmodule

// File: tb/tb_register_file_nr_1w_bist.sv
// Scoreboard bench for register_file_nr_1w_bist (AW=3, DW=16, 2 ports).
module tb_register_file_nr_1w_bist;

   localparam int AW = 3;
   localparam int DW = 16;
   localparam int NP = 2;
   localparam int NB = DW/8;
   localparam int DP = 2**AW;

   logic            clk = 0;
   logic            rst_n = 0;
   logic [NP-1:0]   ReadEnable = '0;
   logic [NP*AW-1:0] ReadAddr = '0;
   logic [NP*DW-1:0] ReadData;
   logic            WriteEnable = 0;
   logic [AW-1:0]   WriteAddr = '0;
   logic [DW-1:0]   WriteData = '0;
   logic [NB-1:0]   WriteBE = '0;
   logic [DP*DW-1:0] MemContent;
   logic            BIST = 0;
   logic            CSN_T = 1;
   logic            WEN_T = 1;
   logic [AW-1:0]   A_T = '0;
   logic [DW-1:0]   D_T = '0;
   logic [NB-1:0]   BE_T = '0;
   logic [DW-1:0]   Q_T;
   logic            bist_start = 0;
   logic            bist_busy;
   logic            bist_done;
   logic            bist_fail;
   logic [AW-1:0]   bist_fail_addr;

   register_file_nr_1w_bist #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RPORTS(NP)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .ReadEnable(ReadEnable), .ReadAddr(ReadAddr), .ReadData(ReadData),
      .WriteEnable(WriteEnable), .WriteAddr(WriteAddr),
      .WriteData(WriteData), .WriteBE(WriteBE),
      .MemContent(MemContent),
      .BIST(BIST), .CSN_T(CSN_T), .WEN_T(WEN_T), .A_T(A_T),
      .D_T(D_T), .BE_T(BE_T), .Q_T(Q_T),
      .bist_start(bist_start), .bist_busy(bist_busy),
      .bist_done(bist_done), .bist_fail(bist_fail),
      .bist_fail_addr(bist_fail_addr)
   );

   always #5 clk = ~clk;

   localparam int S_RD0 = 0, S_RD1 = 1, S_QT = 2, S_MEM = 3;
   localparam int S_BUSY = 4, S_DONE = 5, S_FAIL = 6, S_FADDR = 7;
   localparam int S_BLEN = 8;

   typedef struct {
      int          when;
      int          sel;
      int          arg;
      logic [31:0] exp;
      string       nm;
   } chk_t;

   chk_t q[$];
   int cyc = 0;
   int checks = 0;
   int failures = 0;
   int run = 0;
   int last_len = 0;
   bit prev_busy = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] actual(int sel, int arg);
      case (sel)
         S_RD0:   return 32'(ReadData[DW-1:0]);
         S_RD1:   return 32'(ReadData[2*DW-1:DW]);
         S_QT:    return 32'(Q_T);
         S_MEM:   return 32'(MemContent[arg*DW +: DW]);
         S_BUSY:  return 32'(bist_busy);
         S_DONE:  return 32'(bist_done);
         S_FAIL:  return 32'(bist_fail);
         S_FADDR: return 32'(bist_fail_addr);
         default: return 32'(last_len);
      endcase
   endfunction

   always @(negedge clk) begin
      chk_t c;
      logic [31:0] a;
      if (bist_busy) run++;
      else begin
         if (prev_busy) last_len = run;
         run = 0;
      end
      prev_busy = bist_busy;
      while (q.size() > 0 && q[0].when <= cyc) begin
         c = q.pop_front();
         a = actual(c.sel, c.arg);
         checks++;
         if (c.when != cyc || a != c.exp) begin
            failures++;
            $display("FAIL %s cyc=%0d due=%0d got=%h exp=%h",
                     c.nm, cyc, c.when, a, c.exp);
         end
      end
   end

   task automatic push(int when, int sel, int arg, logic [31:0] e,
                       string nm);
      chk_t c;
      c.when = when; c.sel = sel; c.arg = arg; c.exp = e; c.nm = nm;
      q.push_back(c);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (3) tick();
      rst_n = 1;
      push(cyc, S_RD0, 0, 0, "rst_rd0");
      push(cyc, S_RD1, 0, 0, "rst_rd1");
      push(cyc, S_BUSY, 0, 0, "rst_busy");
      push(cyc, S_DONE, 0, 0, "rst_done");
      push(cyc, S_FAIL, 0, 0, "rst_fail");
      push(cyc, S_FADDR, 0, 0, "rst_faddr");
      tick();

      // byte-enabled write then dual-port read
      WriteEnable = 1; WriteAddr = 5; WriteData = 16'hFFFF; WriteBE = 2'b11;
      tick();
      WriteData = 16'h00A5; WriteBE = 2'b01;
      tick();
      WriteEnable = 0;
      ReadEnable = 2'b11; ReadAddr = {3'd5, 3'd5};
      push(cyc + 1, S_RD0, 0, 32'hFFA5, "be_rd0");
      push(cyc + 1, S_RD1, 0, 32'hFFA5, "be_rd1");
      tick();
      ReadEnable = 2'b00; ReadAddr = '0;
      push(cyc + 1, S_RD0, 0, 32'hFFA5, "hold_rd0");
      tick();

      // read-during-write returns old word
      WriteEnable = 1; WriteAddr = 2; WriteData = 16'h1111; WriteBE = 2'b11;
      tick();
      WriteData = 16'h2222;
      ReadEnable = 2'b10; ReadAddr = {3'd2, 3'd0};
      push(cyc + 1, S_RD1, 0, 32'h1111, "rdw_old");
      tick();
      WriteEnable = 0;
      push(cyc + 1, S_RD1, 0, 32'h2222, "rdw_new");
      tick();
      ReadEnable = 2'b00;
      tick();

      // external test port overrides functional write
      BIST = 1; CSN_T = 0; WEN_T = 0; A_T = 3; D_T = 16'h1234; BE_T = 2'b11;
      WriteEnable = 1; WriteAddr = 3; WriteData = 16'hBEEF; WriteBE = 2'b11;
      tick();
      WriteEnable = 0; WEN_T = 1;
      push(cyc + 1, S_QT, 0, 32'h1234, "ext_qt");
      push(cyc + 1, S_RD1, 0, 0, "ext_rd1_zero");
      push(cyc + 1, S_MEM, 3, 32'h1234, "ext_mem3");
      tick();
      CSN_T = 1; BIST = 0;
      tick();

      // fault-free march
      bist_start = 1;
      push(cyc + 1, S_BUSY, 0, 1, "m_busy_on");
      push(cyc + 82, S_BUSY, 0, 0, "m_busy_off");
      push(cyc + 82, S_DONE, 0, 1, "m_done");
      push(cyc + 82, S_FAIL, 0, 0, "m_fail");
      push(cyc + 82, S_BLEN, 0, 81, "m_busy_len");
      for (int a = 0; a < DP; a++)
         push(cyc + 82, S_MEM, a, 0, $sformatf("m_mem%0d", a));
      tick();
      bist_start = 0;
      repeat (83) tick();

      // stuck-at-1 on word 6 bit 3
      force dut.mem[6][3] = 1'b1;
      bist_start = 1;
      push(cyc + 82, S_DONE, 0, 1, "sa_done");
      push(cyc + 82, S_FAIL, 0, 1, "sa_fail");
      push(cyc + 82, S_FADDR, 0, 6, "sa_faddr");
      tick();
      bist_start = 0;
      repeat (83) tick();
      release dut.mem[6][3];

      // reset mid-march, then a clean rerun
      bist_start = 1;
      tick();
      bist_start = 0;
      repeat (19) tick();
      rst_n = 0;
      push(cyc, S_BUSY, 0, 0, "ab_busy");
      push(cyc, S_DONE, 0, 0, "ab_done");
      push(cyc, S_FAIL, 0, 0, "ab_fail");
      push(cyc, S_RD0, 0, 0, "ab_rd0");
      repeat (2) tick();
      rst_n = 1;
      tick();
      bist_start = 1;
      push(cyc + 82, S_BLEN, 0, 81, "re_busy_len");
      push(cyc + 82, S_DONE, 0, 1, "re_done");
      push(cyc + 82, S_FAIL, 0, 0, "re_fail");
      tick();
      bist_start = 0;
      repeat (84) tick();

      if (q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL pending got=%0d exp=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
